vga_text_reader: RTL

- Display-side reader for the 2048x32 dual-port VGA RAM. Drives the RAM's read-only port B (addrb/rdb) and an external 8x16 font ROM.
- Generates 640x480@60 timing from one pixel clock (25.175/25 MHz) and renders an 80x30 character text screen to 12-bit RGB.
- Sits between the VGA RAM and the board VGA connector. The CPU writes text through port A and never touches this block.

---
 rtl/vga_text_reader.sv | 131 +++++++++++++
 1 files changed

// File: rtl/vga_text_reader.sv
// vga_text_reader: 640x480@60 text-mode scanout, 80x30 cells read from VGA RAM port B
// through an external 8x16 font ROM to 12-bit RGB, three cycles from counters to pins.
module vga_text_reader #(
    parameter logic [10:0] BASE_ADDR = 11'd0,
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic        clk,
    input  logic        rst,
    output logic [10:0] vram_addr,
    input  logic [31:0] vram_data,
    output logic [11:0] font_addr,
    input  logic [7:0]  font_data,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        frame_start
);
    localparam logic [9:0] H_LAST = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_ACT  = 10'(H_VIS);
    localparam logic [9:0] V_ACT  = 10'(V_VIS);
    localparam logic [9:0] HS_BEG = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END = 10'(V_VIS + V_FP + V_SYNC);

    function automatic logic [3:0] chan(input logic b, input logic i);
        return b ? (i ? 4'hF : 4'hA) : 4'h0;
    endfunction

    logic [9:0]  r_h, r_v, w_h_nxt, w_v_nxt;
    logic [10:0] w_addr_nxt;
    logic        w_act0, w_hs0, w_vs0, w_fs0;
    logic        r_act1, r_hs1, r_vs1, r_fs1, r_par1;
    logic [2:0]  r_px1;
    logic [3:0]  r_row1;
    logic        r_act2, r_hs2, r_vs2, r_fs2;
    logic [2:0]  r_px2;
    logic [7:0]  r_attr2;
    logic [15:0] w_half;
    logic        w_pix;
    logic [3:0]  w_irgb;

    // vram_addr is computed from the next counter values so the RAM sees the
    // address of the current stage-0 position, keeping total latency at three.
    always_comb begin
        w_h_nxt    = (r_h == H_LAST) ? '0 : r_h + 10'd1;
        w_v_nxt    = (r_h != H_LAST) ? r_v : (r_v == V_LAST) ? '0 : r_v + 10'd1;
        w_addr_nxt = BASE_ADDR + 11'(w_v_nxt[8:4]) * 11'd40 + 11'(w_h_nxt[9:4]);
        w_act0     = (r_h < H_ACT) && (r_v < V_ACT);
        w_hs0      = !((r_h >= HS_BEG) && (r_h < HS_END));
        w_vs0      = !((r_v >= VS_BEG) && (r_v < VS_END));
        w_fs0      = (r_h == '0) && (r_v == '0);
        w_half     = r_par1 ? vram_data[15:0] : vram_data[31:16];
        font_addr  = {w_half[15:8], r_row1};
        w_pix      = font_data[3'd7 - r_px2];
        w_irgb     = w_pix ? r_attr2[3:0] : r_attr2[7:4];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_h       <= '0;
            r_v       <= '0;
            vram_addr <= BASE_ADDR;
        end else begin
            r_h       <= w_h_nxt;
            r_v       <= w_v_nxt;
            vram_addr <= w_addr_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_act1  <= 1'b0;
            r_hs1   <= 1'b1;
            r_vs1   <= 1'b1;
            r_fs1   <= 1'b0;
            r_par1  <= 1'b0;
            r_px1   <= '0;
            r_row1  <= '0;
            r_act2  <= 1'b0;
            r_hs2   <= 1'b1;
            r_vs2   <= 1'b1;
            r_fs2   <= 1'b0;
            r_px2   <= '0;
            r_attr2 <= '0;
        end else begin
            r_act1  <= w_act0;
            r_hs1   <= w_hs0;
            r_vs1   <= w_vs0;
            r_fs1   <= w_fs0;
            r_par1  <= r_h[3];
            r_px1   <= r_h[2:0];
            r_row1  <= r_v[3:0];
            r_act2  <= r_act1;
            r_hs2   <= r_hs1;
            r_vs2   <= r_vs1;
            r_fs2   <= r_fs1;
            r_px2   <= r_px1;
            r_attr2 <= w_half[7:0];
        end
    end

    // Palette: each channel is {colour bit, intensity} -> 0, 0, A, F.
    always_ff @(posedge clk) begin
        if (rst) begin
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            vga_hsync   <= 1'b1;
            vga_vsync   <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            vga_r       <= r_act2 ? chan(w_irgb[2], w_irgb[3]) : 4'h0;
            vga_g       <= r_act2 ? chan(w_irgb[1], w_irgb[3]) : 4'h0;
            vga_b       <= r_act2 ? chan(w_irgb[0], w_irgb[3]) : 4'h0;
            vga_hsync   <= r_hs2;
            vga_vsync   <= r_vs2;
            frame_start <= r_fs2;
        end
    end
endmodule
